div_stall_unit: RTL

- Multi-cycle 32-bit integer divider for MIPS DIV/DIVU, placed in the EX stage.
- Produces the `stall`/`done` handshake that the hazard detection/control unit consumes: `stall` freezes the pipeline while the divide runs, and a one-cycle `done` releases it.
- `cancel` connects to the exception-flush path so a divide in flight can be aborted.
- Results go to the HI/LO write path: remainder→HI, quotient→LO.

---
 rtl/div_stall_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/div_stall_unit.sv
// div_stall_unit
//   Multi-cycle restoring divider for MIPS DIV/DIVU in the EX stage. It raises
//   a stall while a divide runs and emits a one-cycle done pulse when the
//   HI/LO results are ready.
//   Ports:
//     clk, rst              clock; synchronous active-high reset
//     start, is_signed      DIV/DIVU request (is_signed=1 -> DIV)
//     cancel                exception flush, aborts any operation
//     dividend, divisor     rs / rt operands, sampled on accept
//     quotient, remainder   LO / HI results, held until the next completion
//     stall                 combinational pipeline hold request
//     done                  registered one-cycle result-valid pulse
module div_stall_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             stall,
    output logic             done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;    // partial remainder
    logic [WIDTH-1:0] quo_q;    // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_mag;
    logic             neg_q;    // negate quotient at the end
    logic             neg_r;    // negate remainder at the end

    logic accept;
    assign accept = (state != S_CALC) && start && !cancel;

    // Held low during reset so the pipeline is never frozen by a stale state.
    assign stall = !rst && ((state == S_CALC) || accept);

    // Operand magnitudes; 0x80000000 maps onto itself, read as unsigned.
    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    assign dvd_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_abs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // One restoring step. rem_q < dvs_mag always, so the shifted value fits in
    // WIDTH+1 bits and the trial's top bit is a valid borrow/sign flag.
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] rem_nx, quo_nx, q_fix, r_fix;
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_mag};
        if (!trial[WIDTH]) begin
            rem_nx = trial[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b0};
        end
        q_fix = neg_q ? -quo_nx : quo_nx;
        r_fix = neg_r ? -rem_nx : rem_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_mag   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                // Abort; previous results stay visible on quotient/remainder.
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_CALC: begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            quotient  <= q_fix;
                            remainder <= r_fix;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                    default: begin
                        // IDLE or DONE: a new request may be taken here,
                        // including back-to-back in the done cycle.
                        if (accept) begin
                            rem_q   <= '0;
                            quo_q   <= dvd_abs;
                            dvs_mag <= dvs_abs;
                            // Zero divisor has sign bit 0, so it counts as positive.
                            neg_q   <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_r   <= is_signed && dividend[WIDTH-1];
                            cnt     <= '0;
                            state   <= S_CALC;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end
endmodule
